rx_dwidth_conv: RTL and testbench

// Receive-side gearbox: packs a stream of narrow lane words into full-width frame words,

---
 rtl/rx_dwidth_conv.sv | 132 +++++++++++++
 tb/tb_rx_dwidth_conv.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_dwidth_conv.sv
// Receive gearbox: packs MSB-first narrow lane slices into wide frame words.
// Tracks sof alignment, pulses align_err on phase violations, re-locks on sof.
module rx_dwidth_conv #(
    parameter int DWIDTH_IN  = 64,
    parameter int DWIDTH_OUT = 256,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DWIDTH_IN-1:0]  din,
    input  logic                  din_valid,
    input  logic                  sof_in,
    output logic [DWIDTH_OUT-1:0] dout,
    output logic                  dout_valid,
    output logic                  locked,
    output logic                  align_err
);

    localparam int RATIO = (DWIDTH_OUT > DWIDTH_IN) ? DWIDTH_OUT / DWIDTH_IN : 1;

    generate
        if (RATIO == 1) begin : g_pass
            logic [DWIDTH_OUT-1:0] dout_q;
            logic                  dv_q;
            logic                  lk_q;
            logic                  unused_bits;

            assign unused_bits = ^{sof_in, din};

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dout_q <= '0;
                    dv_q   <= 1'b0;
                    lk_q   <= 1'b0;
                end else begin
                    dout_q <= din[DWIDTH_OUT-1:0];
                    dv_q   <= din_valid;
                    lk_q   <= 1'b1;
                end
            end

            assign dout       = dout_q;
            assign dout_valid = dv_q;
            assign locked     = lk_q;
            assign align_err  = 1'b0;
        end else begin : g_pack
            typedef enum logic {
                UNLOCKED,
                LOCKED
            } state_t;

            localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(RATIO - 1);
            localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

            state_t                state_q, state_d;
            logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
            logic [DWIDTH_OUT-1:0] sr_q, sr_d;
            logic [DWIDTH_OUT-1:0] dout_q, dout_d;
            logic                  dv_q, dv_d;
            logic                  err_q, err_d;
            logic [DWIDTH_OUT-1:0] shifted;
            logic [DWIDTH_OUT-1:0] loaded;

            // New slices enter at the LSB end so slice 0 ends up in the MSBs.
            assign shifted = {sr_q[DWIDTH_OUT-DWIDTH_IN-1:0], din};
            assign loaded  = {{(DWIDTH_OUT-DWIDTH_IN){1'b0}}, din};

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_q <= UNLOCKED;
                    cnt_q   <= '0;
                    sr_q    <= '0;
                    dout_q  <= '0;
                    dv_q    <= 1'b0;
                    err_q   <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    sr_q    <= sr_d;
                    dout_q  <= dout_d;
                    dv_q    <= dv_d;
                    err_q   <= err_d;
                end
            end

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                sr_d    = sr_q;
                dout_d  = dout_q;
                dv_d    = 1'b0;
                err_d   = 1'b0;
                if (din_valid) begin
                    unique case (state_q)
                        UNLOCKED: begin
                            if (sof_in) begin
                                sr_d    = loaded;
                                cnt_d   = ONE;
                                state_d = LOCKED;
                            end
                        end
                        LOCKED: begin
                            if (sof_in) begin
                                // an early sof discards the partial word
                                sr_d  = loaded;
                                cnt_d = ONE;
                                err_d = (cnt_q != '0);
                            end else if (cnt_q == '0) begin
                                err_d   = 1'b1;
                                state_d = UNLOCKED;
                            end else if (cnt_q == LAST) begin
                                dout_d = shifted;
                                dv_d   = 1'b1;
                                cnt_d  = '0;
                            end else begin
                                sr_d  = shifted;
                                cnt_d = cnt_q + ONE;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            assign dout       = dout_q;
            assign dout_valid = dv_q;
            assign locked     = (state_q == LOCKED);
            assign align_err  = err_q;
        end
    endgenerate

endmodule

// File: tb/tb_rx_dwidth_conv.sv
// Scoreboard bench for rx_dwidth_conv: 64->256 packer and 64->64 pass-through.
// Queue-based reference model predicts every cycle's outputs.
module tb_rx_dwidth_conv;

    localparam int RATIO = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [63:0]  din = '0;
    logic         din_valid = 1'b0;
    logic         sof_in = 1'b0;
    logic [255:0] dout;
    logic         dout_valid, locked, align_err;
    logic [63:0]  p_dout;
    logic         p_dv, p_locked, p_err;

    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rx_dwidth_conv #(.DWIDTH_IN(64), .DWIDTH_OUT(256), .CNT_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .sof_in(sof_in), .dout(dout), .dout_valid(dout_valid),
        .locked(locked), .align_err(align_err)
    );

    rx_dwidth_conv #(.DWIDTH_IN(64), .DWIDTH_OUT(64), .CNT_WIDTH(1)) dut_pt (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .sof_in(sof_in), .dout(p_dout), .dout_valid(p_dv),
        .locked(p_locked), .align_err(p_err)
    );

    typedef struct {
        bit           dv;
        bit           err;
        bit           lock;
        logic [255:0] dout;
        bit           pdv;
        bit           plock;
        logic [63:0]  pdout;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] m_slices[$];
    bit          m_lock = 0;
    logic [255:0] m_dout = '0;
    bit          m_plock = 0;

    task automatic chk(string name, logic [255:0] act, logic [255:0] want);
        checks++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Reference model: a word is the sof slice plus the next RATIO-1 slices.
    task automatic cyc(bit rst, bit v, bit s, logic [63:0] d);
        exp_t e;
        e.dv = 0;
        e.err = 0;
        e.pdv = 0;
        e.pdout = '0;
        if (rst) begin
            m_lock = 0;
            m_slices.delete();
            m_dout = '0;
            m_plock = 0;
        end else begin
            m_plock = 1;
            e.pdv = v;
            e.pdout = d;
            if (v) begin
                if (s) begin
                    if (m_lock && m_slices.size() > 0) e.err = 1;
                    m_slices.delete();
                    m_slices.push_back(d);
                    m_lock = 1;
                end else if (m_lock) begin
                    if (m_slices.size() == 0) begin
                        e.err = 1;
                        m_lock = 0;
                    end else begin
                        m_slices.push_back(d);
                        if (m_slices.size() == RATIO) begin
                            m_dout = {m_slices[0], m_slices[1], m_slices[2], m_slices[3]};
                            e.dv = 1;
                            m_slices.delete();
                        end
                    end
                end
            end
        end
        e.lock = m_lock;
        e.dout = m_dout;
        e.plock = m_plock;
        @(negedge clk);
        rst_n = ~rst;
        din_valid = v;
        sof_in = s;
        din = d;
        exp_q.push_back(e);
    endtask

    task automatic word(logic [63:0] a, b, c, d2);
        cyc(0, 1, 1, a);
        cyc(0, 1, 0, b);
        cyc(0, 1, 0, c);
        cyc(0, 1, 0, d2);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 64'($urandom));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("dout_valid", 256'(dout_valid), 256'(e.dv));
                chk("align_err", 256'(align_err), 256'(e.err));
                chk("locked", 256'(locked), 256'(e.lock));
                chk("dout", dout, e.dout);
                chk("pt_dout_valid", 256'(p_dv), 256'(e.pdv));
                chk("pt_locked", 256'(p_locked), 256'(e.plock));
                chk("pt_align_err", 256'(p_err), 256'(0));
                if (e.pdv) chk("pt_dout", 256'(p_dout), 256'(e.pdout));
            end
        end
    end

    logic [63:0] A = {16{4'h1}};
    logic [63:0] B = {16{4'h2}};
    logic [63:0] C = {16{4'h3}};
    logic [63:0] D = {16{4'h4}};
    logic [63:0] X = {16{4'h9}};
    logic [63:0] Y = {16{4'hA}};
    logic [63:0] Z = {16{4'hB}};
    logic [63:0] W = {16{4'hC}};

    initial begin : stim
        int pos;
        int budget;
        bit s;
        bit v;
        cyc(1, 0, 0, '0);
        cyc(1, 1, 1, A);
        // 1: one clean word
        word(A, B, C, D);
        idle(2);
        // 2: gapped beats for two words
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < RATIO; k++) begin
                cyc(0, 1, k == 0, 64'({$urandom, $urandom}));
                cyc(0, 0, 0, 64'($urandom));
            end
        end
        // 3: junk before first sof
        cyc(1, 0, 0, '0);
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 64'($urandom));
        word(X, Y, Z, W);
        // 4: early sof discards A/B
        cyc(0, 1, 1, A);
        cyc(0, 1, 0, B);
        word(X, Y, Z, W);
        idle(1);
        // 5: missing sof after a good word, then relock
        cyc(0, 1, 0, C);
        idle(1);
        word(D, C, B, A);
        // 6: reset mid-word
        cyc(0, 1, 1, A);
        cyc(0, 1, 0, B);
        cyc(1, 1, 0, C);
        cyc(1, 0, 0, D);
        word(W, Z, Y, X);
        idle(1);
        // random traffic with occasional phase errors and resets
        pos = 0;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(3) != 0);
            s = (pos == 0);
            if ($urandom_range(19) == 0) s = ~s;
            if ($urandom_range(149) == 0) begin
                cyc(1, v, s, 64'({$urandom, $urandom}));
                pos = 0;
            end else begin
                cyc(0, v, s, 64'({$urandom, $urandom}));
                if (v) pos = s ? 1 : (pos + 1) % RATIO;
            end
        end
        idle(2);
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
